// File: rtl/tile_scheduler_if.sv
// tile_scheduler_if: config, weight-controller, IF-stream and drain handshakes of the tile scheduler.
interface tile_scheduler_if #(
   parameter int KT_W = 8,
   parameter int NT_W = 8
);
   logic            cfg_valid, cfg_ready;
   logic [KT_W-1:0] cfg_k_tiles;
   logic [NT_W-1:0] cfg_n_tiles;
   logic            w_start, w_ready;
   logic            if_ready, if_launch, if_done, acc_clr;
   logic            drain_start, drain_done;
   logic [KT_W-1:0] k_idx;
   logic [NT_W-1:0] n_idx;
   logic            busy, layer_done, proto_err;
   modport master (
      input  cfg_valid, cfg_k_tiles, cfg_n_tiles, w_ready, if_launch, if_done, drain_done,
      output cfg_ready, w_start, if_ready, acc_clr, drain_start, k_idx, n_idx, busy, layer_done, proto_err
   );
   modport slave (
      output cfg_valid, cfg_k_tiles, cfg_n_tiles, w_ready, if_launch, if_done, drain_done,
      input  cfg_ready, w_start, if_ready, acc_clr, drain_start, k_idx, n_idx, busy, layer_done, proto_err
   );
endinterface

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks N x K tiles (k innermost), issuing weight fetches, gating IF launches and triggering drains.
module tile_scheduler #(
   parameter int KT_W = 8,
   parameter int NT_W = 8
) (
   input logic              clk,
   input logic              rst,
   tile_scheduler_if.master bus
);
   localparam int CW = KT_W + NT_W;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t          r_state;
   logic [KT_W-1:0] r_k, r_k_idx;
   logic [NT_W-1:0] r_n, r_n_idx;
   logic [CW-1:0]   r_issued, r_launched;
   logic            r_w_start, r_drain_start, r_layer_done, r_acc_clr, r_proto_err, r_if_busy, r_if_ready_q;
   logic [CW-1:0]   w_total;
   logic [KT_W-1:0] w_k_next;
   logic            w_active, w_if_ready, w_issue, w_done, w_last_k, w_launch;
   assign w_total    = CW'(r_k) * CW'(r_n);
   assign w_active   = r_state == RUN || r_state == DRAIN;
   assign w_if_ready = r_state == RUN && !r_if_busy && r_launched < r_issued;
   // the blanking cycle hides the weight controller's registered ready fall
   assign w_issue    = w_active && bus.w_ready && r_issued < w_total && !r_w_start;
   assign w_done     = r_state == RUN && bus.if_done && r_if_busy;
   assign w_last_k   = r_k_idx == r_k - KT_W'(1);
   assign w_launch   = w_active && bus.if_launch;
   assign w_k_next   = w_done ? (w_last_k ? '0 : r_k_idx + KT_W'(1)) : r_k_idx;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_k           <= '0;
         r_n           <= '0;
         r_k_idx       <= '0;
         r_n_idx       <= '0;
         r_issued      <= '0;
         r_launched    <= '0;
         r_w_start     <= 1'b0;
         r_drain_start <= 1'b0;
         r_layer_done  <= 1'b0;
         r_acc_clr     <= 1'b0;
         r_proto_err   <= 1'b0;
         r_if_busy     <= 1'b0;
         r_if_ready_q  <= 1'b0;
      end else begin
         r_w_start     <= w_issue;
         r_issued      <= r_issued + CW'(w_issue);
         r_drain_start <= 1'b0;
         r_layer_done  <= 1'b0;
         r_if_ready_q  <= w_if_ready;
         r_k_idx       <= w_k_next;
         if (bus.if_launch && !r_if_ready_q) r_proto_err <= 1'b1;
         // completion is applied before a coincident launch
         if (w_done) r_if_busy <= 1'b0;
         if (w_launch) begin
            r_if_busy  <= 1'b1;
            r_launched <= r_launched + CW'(1);
            r_acc_clr  <= w_k_next == '0;
         end
         case (r_state)
            IDLE: if (bus.cfg_valid) begin
               r_k        <= bus.cfg_k_tiles;
               r_n        <= bus.cfg_n_tiles;
               r_issued   <= '0;
               r_launched <= '0;
               r_k_idx    <= '0;
               r_n_idx    <= '0;
               r_state    <= (bus.cfg_k_tiles == '0 || bus.cfg_n_tiles == '0) ? DONE : RUN;
            end
            RUN: if (w_done && w_last_k) begin
               r_drain_start <= 1'b1;
               r_state       <= DRAIN;
            end
            DRAIN: if (bus.drain_done) begin
               r_n_idx <= (r_n_idx == r_n - NT_W'(1)) ? r_n_idx : r_n_idx + NT_W'(1);
               r_state <= (r_n_idx == r_n - NT_W'(1)) ? DONE : RUN;
            end
            default: begin
               r_layer_done <= 1'b1;
               r_state      <= IDLE;
            end
         endcase
      end
   end
   assign bus.cfg_ready   = r_state == IDLE;
   assign bus.busy        = r_state != IDLE;
   assign bus.w_start     = r_w_start;
   assign bus.if_ready    = w_if_ready;
   assign bus.acc_clr     = r_acc_clr;
   assign bus.drain_start = r_drain_start;
   assign bus.layer_done  = r_layer_done;
   assign bus.proto_err   = r_proto_err;
   assign bus.k_idx       = r_k_idx;
   assign bus.n_idx       = r_n_idx;
endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: table-driven layer runs against a behavioural weight/IF/drain environment, plus corner sequences.
module tb_tile_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   tile_scheduler_if #(.KT_W(8), .NT_W(8)) bus ();
   tile_scheduler #(.KT_W(8), .NT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      int k, n, hold, ddly, ws, dr, ln, acc, kf, nf;
   } vec_t;
   vec_t tbl[6];
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic run_layer(input vec_t v);
      int ws = 0, dr = 0, ld = 0, ln = 0, consec = 0, drbad = 0, rdybad = 0;
      int ldly = 0, dd = 0, rdly = 0;
      logic [31:0] acc = '0;
      bit ws_prev = 0, launched_prev = 0, in_drain = 0, chk_rdy = 0;
      bus.cfg_k_tiles = 8'(v.k);
      bus.cfg_n_tiles = 8'(v.n);
      bus.cfg_valid = 1'b1;
      bus.w_ready = 1'b1;
      for (int cyc = 0; cyc < 3000 && ld == 0; cyc++) begin
         step();
         bus.cfg_valid = 1'b0;
         bus.if_launch = 1'b0;
         bus.if_done = 1'b0;
         bus.drain_done = 1'b0;
         if (chk_rdy) begin
            if (bus.if_ready !== (dr < v.n)) rdybad++;
            chk_rdy = 0;
         end
         if (in_drain && bus.if_ready) drbad++;
         if (launched_prev) begin
            if (ln <= 32) acc[ln-1] = bus.acc_clr;
            launched_prev = 0;
         end
         if (bus.w_start) begin
            ws++;
            if (ws_prev) consec++;
         end
         bus.w_ready = (v.hold != 0) ? 1'b1 : !ws_prev;
         ws_prev = bus.w_start;
         if (bus.drain_start) begin
            dr++;
            in_drain = 1;
            rdly = v.ddly;
         end else if (rdly > 0) begin
            rdly--;
            if (rdly == 0) begin
               bus.drain_done = 1'b1;
               in_drain = 0;
               chk_rdy = 1;
            end
         end
         if (dd > 0) begin
            dd--;
            if (dd == 0) bus.if_done = 1'b1;
         end
         if (ldly == 1) begin
            bus.if_launch = 1'b1;
            ldly = 0;
            ln++;
            launched_prev = 1;
            dd = 8;
         end else if (ldly > 1) ldly--;
         else if (bus.if_ready) ldly = 2;
         if (bus.layer_done) ld++;
      end
      chk("layer_done_seen", 32'(ld), 32'd1);
      chk("w_start_count", 32'(ws), 32'(v.ws));
      chk("drain_count", 32'(dr), 32'(v.dr));
      chk("launch_count", 32'(ln), 32'(v.ln));
      chk("acc_clr_pattern", acc, 32'(v.acc));
      chk("final_k_idx", 32'(bus.k_idx), 32'(v.kf));
      chk("final_n_idx", 32'(bus.n_idx), 32'(v.nf));
      chk("w_start_back_to_back", 32'(consec), 32'd0);
      chk("if_ready_in_drain", 32'(drbad), 32'd0);
      chk("if_ready_after_drain", 32'(rdybad), 32'd0);
      chk("proto_err_clean", 32'(bus.proto_err), 32'd0);
      chk("cfg_ready_at_done", 32'(bus.cfg_ready), 32'd1);
      step();
      chk("layer_done_one_cycle", 32'(bus.layer_done), 32'd0);
      chk("busy_after_layer", 32'(bus.busy), 32'd0);
   endtask
   initial begin
      tbl[0] = '{k:3, n:2, hold:0, ddly:3,  ws:6, dr:2, ln:6, acc:'h09, kf:0, nf:1};
      tbl[1] = '{k:3, n:2, hold:1, ddly:20, ws:6, dr:2, ln:6, acc:'h09, kf:0, nf:1};
      tbl[2] = '{k:0, n:5, hold:0, ddly:3,  ws:0, dr:0, ln:0, acc:'h00, kf:0, nf:0};
      tbl[3] = '{k:4, n:0, hold:0, ddly:3,  ws:0, dr:0, ln:0, acc:'h00, kf:0, nf:0};
      tbl[4] = '{k:1, n:1, hold:0, ddly:3,  ws:1, dr:1, ln:1, acc:'h01, kf:0, nf:0};
      tbl[5] = '{k:2, n:3, hold:1, ddly:5,  ws:6, dr:3, ln:6, acc:'h15, kf:0, nf:2};
      bus.cfg_valid = 1'b0;
      bus.cfg_k_tiles = '0;
      bus.cfg_n_tiles = '0;
      bus.w_ready = 1'b1;
      bus.if_launch = 1'b0;
      bus.if_done = 1'b0;
      bus.drain_done = 1'b0;
      step();
      step();
      chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_w_start", 32'(bus.w_start), 32'd0);
      chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
      chk("rst_acc_clr", 32'(bus.acc_clr), 32'd0);
      chk("rst_drain_start", 32'(bus.drain_start), 32'd0);
      chk("rst_layer_done", 32'(bus.layer_done), 32'd0);
      chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
      chk("rst_k_idx", 32'(bus.k_idx), 32'd0);
      chk("rst_n_idx", 32'(bus.n_idx), 32'd0);
      rst = 1'b0;
      step();
      foreach (tbl[i]) run_layer(tbl[i]);
      bus.cfg_k_tiles = 8'd0;
      bus.cfg_n_tiles = 8'd5;
      bus.cfg_valid = 1'b1;
      step();
      bus.cfg_valid = 1'b0;
      chk("k0_busy_c1", 32'(bus.busy), 32'd1);
      chk("k0_layer_done_c1", 32'(bus.layer_done), 32'd0);
      step();
      chk("k0_layer_done_c2", 32'(bus.layer_done), 32'd1);
      chk("k0_cfg_ready_c2", 32'(bus.cfg_ready), 32'd1);
      step();
      bus.if_launch = 1'b1;
      step();
      bus.if_launch = 1'b0;
      chk("proto_err_set", 32'(bus.proto_err), 32'd1);
      chk("proto_err_no_busy", 32'(bus.busy), 32'd0);
      repeat (5) step();
      chk("proto_err_sticky", 32'(bus.proto_err), 32'd1);
      bus.cfg_k_tiles = 8'd3;
      bus.cfg_n_tiles = 8'd2;
      bus.cfg_valid = 1'b1;
      step();
      bus.cfg_valid = 1'b0;
      begin
         int t = 0;
         while (!bus.if_ready && t < 50) begin
            step();
            t++;
         end
         chk("midrst_if_ready_seen", 32'(bus.if_ready), 32'd1);
      end
      step();
      bus.if_launch = 1'b1;
      step();
      bus.if_launch = 1'b0;
      chk("midrst_acc_clr_first", 32'(bus.acc_clr), 32'd1);
      repeat (3) step();
      bus.if_done = 1'b1;
      step();
      bus.if_done = 1'b0;
      chk("midrst_k_idx_1", 32'(bus.k_idx), 32'd1);
      chk("midrst_busy_before", 32'(bus.busy), 32'd1);
      chk("proto_err_sticky_run", 32'(bus.proto_err), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk("midrst_k_idx", 32'(bus.k_idx), 32'd0);
      chk("midrst_n_idx", 32'(bus.n_idx), 32'd0);
      chk("midrst_proto_err", 32'(bus.proto_err), 32'd0);
      step();
      chk("midrst_no_drain", 32'(bus.drain_start), 32'd0);
      chk("midrst_no_layer_done", 32'(bus.layer_done), 32'd0);
      chk("midrst_no_w_start", 32'(bus.w_start), 32'd0);
      run_layer(tbl[0]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
